// File: rtl/seg7_pkg.sv
// seg7_pkg
// Shared definitions for the seven-segment readback path:
//   - SEG7_HEX_0..SEG7_HEX_F : active-low segment patterns (bit0=a .. bit6=g)
//   - SEG7_BLANK             : all segments off
//   - seg7_state_e           : frame FSM states
package seg7_pkg;

  localparam logic [6:0] SEG7_HEX_0 = 7'h40;
  localparam logic [6:0] SEG7_HEX_1 = 7'h79;
  localparam logic [6:0] SEG7_HEX_2 = 7'h24;
  localparam logic [6:0] SEG7_HEX_3 = 7'h30;
  localparam logic [6:0] SEG7_HEX_4 = 7'h19;
  localparam logic [6:0] SEG7_HEX_5 = 7'h12;
  localparam logic [6:0] SEG7_HEX_6 = 7'h02;
  localparam logic [6:0] SEG7_HEX_7 = 7'h78;
  localparam logic [6:0] SEG7_HEX_8 = 7'h00;
  localparam logic [6:0] SEG7_HEX_9 = 7'h10;
  localparam logic [6:0] SEG7_HEX_A = 7'h08;
  localparam logic [6:0] SEG7_HEX_B = 7'h03;
  localparam logic [6:0] SEG7_HEX_C = 7'h46;
  localparam logic [6:0] SEG7_HEX_D = 7'h21;
  localparam logic [6:0] SEG7_HEX_E = 7'h06;
  localparam logic [6:0] SEG7_HEX_F = 7'h0E;

  localparam logic [6:0] SEG7_BLANK = 7'h7F;

  typedef enum logic {
    COLLECT = 1'b0,
    PRESENT = 1'b1
  } seg7_state_e;

endpackage

// File: rtl/seg7_pattern_to_nibble.sv
// seg7_pattern_to_nibble
// Combinational inverse of the hex display decoder.
// Ports:
//   pattern_i [6:0] : active-low segment pattern
//   nibble_o  [3:0] : recovered hex digit (0 when the pattern is not in the table)
//   invalid_o       : 1 when the pattern matches no hex digit
module seg7_pattern_to_nibble
  import seg7_pkg::*;
(
  input  logic [6:0] pattern_i,
  output logic [3:0] nibble_o,
  output logic       invalid_o
);

  always_comb begin
    nibble_o  = 4'h0;
    invalid_o = 1'b0;
    case (pattern_i)
      SEG7_HEX_0: nibble_o = 4'h0;
      SEG7_HEX_1: nibble_o = 4'h1;
      SEG7_HEX_2: nibble_o = 4'h2;
      SEG7_HEX_3: nibble_o = 4'h3;
      SEG7_HEX_4: nibble_o = 4'h4;
      SEG7_HEX_5: nibble_o = 4'h5;
      SEG7_HEX_6: nibble_o = 4'h6;
      SEG7_HEX_7: nibble_o = 4'h7;
      SEG7_HEX_8: nibble_o = 4'h8;
      SEG7_HEX_9: nibble_o = 4'h9;
      SEG7_HEX_A: nibble_o = 4'hA;
      SEG7_HEX_B: nibble_o = 4'hB;
      SEG7_HEX_C: nibble_o = 4'hC;
      SEG7_HEX_D: nibble_o = 4'hD;
      SEG7_HEX_E: nibble_o = 4'hE;
      SEG7_HEX_F: nibble_o = 4'hF;
      default:    invalid_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg7_scan_encoder.sv
// seg7_scan_encoder
// Samples a multiplexed active-low 4-digit seven-segment bus, debounces each
// digit, decodes it back to a nibble and presents a 16-bit frame on valid/ready.
// Ports:
//   clk, rst_n             : clock, asynchronous active-low reset
//   seg_n [6:0]            : segment bus, active-low
//   an_n  [3:0]            : digit enables, active-low, bit k = digit k
//   out_ready              : consumer accepts the presented frame
//   value [15:0]           : value[4k+3:4k] = nibble of digit k
//   value_valid            : frame present
//   invalid_mask [3:0]     : digit k pattern was not a hex pattern
//   frame_err              : more than one enable seen low during collection
module seg7_scan_encoder
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  seg_n,
  input  logic [3:0]  an_n,
  input  logic        out_ready,
  output logic [15:0] value,
  output logic        value_valid,
  output logic [3:0]  invalid_mask,
  output logic        frame_err
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] STABLE_MAX = CW'(STABLE_CYCLES);

  logic [6:0]    sampleSeg_q, prevSeg_q;
  logic [3:0]    sampleAn_q, prevAn_q;
  logic [CW-1:0] stableCnt_q, stableCnt_d;
  logic [3:0]    captured_q, captured_d;
  logic [15:0]   value_q, value_d;
  logic [3:0]    invalid_q, invalid_d;
  logic          err_q, err_d;
  seg7_state_e   state_q, state_d;

  logic [2:0]    lowCount;
  logic [1:0]    digitIdx;
  logic          oneActive;
  logic          multiActive;
  logic          samePair;
  logic          captureHit;
  logic [3:0]    decNibble;
  logic          decInvalid;

  // Sample stage plus a one-deep history of the sample, used to detect dwell.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sampleSeg_q <= SEG7_BLANK;
      sampleAn_q  <= 4'hF;
      prevSeg_q   <= SEG7_BLANK;
      prevAn_q    <= 4'hF;
    end else begin
      sampleSeg_q <= seg_n;
      sampleAn_q  <= an_n;
      prevSeg_q   <= sampleSeg_q;
      prevAn_q    <= sampleAn_q;
    end
  end

  always_comb begin
    lowCount = 3'd0;
    digitIdx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (!sampleAn_q[i]) begin
        lowCount = lowCount + 3'd1;
        digitIdx = 2'(i);
      end
    end
  end

  assign oneActive   = (lowCount == 3'd1);
  assign multiActive = (lowCount >= 3'd2);
  // With a single enable low, equal enable vectors imply equal digit index.
  assign samePair    = (sampleSeg_q == prevSeg_q) && (sampleAn_q == prevAn_q);

  // Saturation at STABLE_MAX is what limits a dwell to a single capture.
  always_comb begin
    stableCnt_d = '0;
    if (oneActive) begin
      if (!samePair) begin
        stableCnt_d = CW'(1);
      end else if (stableCnt_q == STABLE_MAX) begin
        stableCnt_d = stableCnt_q;
      end else begin
        stableCnt_d = stableCnt_q + CW'(1);
      end
    end
  end

  assign captureHit = oneActive && (stableCnt_d == STABLE_MAX) && (stableCnt_q != STABLE_MAX);

  seg7_pattern_to_nibble u_lookup (
    .pattern_i (sampleSeg_q),
    .nibble_o  (decNibble),
    .invalid_o (decInvalid)
  );

  // Frame FSM. Captures land only in COLLECT, so a capture coinciding with the
  // handshake edge is dropped; the COLLECT->PRESENT decision uses the capture
  // set from before the edge, so a last-moment recapture still lands.
  always_comb begin
    state_d    = state_q;
    captured_d = captured_q;
    value_d    = value_q;
    invalid_d  = invalid_q;
    err_d      = err_q;
    case (state_q)
      COLLECT: begin
        if (multiActive) begin
          err_d = 1'b1;
        end
        if (captureHit) begin
          value_d[4*digitIdx +: 4] = decNibble;
          invalid_d[digitIdx]      = decInvalid;
          captured_d[digitIdx]     = 1'b1;
        end
        if (captured_q == 4'b1111) begin
          state_d = PRESENT;
        end
      end
      PRESENT: begin
        if (out_ready) begin
          state_d    = COLLECT;
          captured_d = 4'b0000;
          err_d      = 1'b0;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= COLLECT;
      stableCnt_q <= '0;
      captured_q  <= 4'b0000;
      value_q     <= 16'h0000;
      invalid_q   <= 4'b0000;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      stableCnt_q <= stableCnt_d;
      captured_q  <= captured_d;
      value_q     <= value_d;
      invalid_q   <= invalid_d;
      err_q       <= err_d;
    end
  end

  assign value        = value_q;
  assign value_valid  = (state_q == PRESENT);
  assign invalid_mask = invalid_q;
  assign frame_err    = err_q;

endmodule

// File: tb/tb_seg7_scan_encoder.sv
// tb_seg7_scan_encoder
// Self-checking bench: directed frames, a table of pattern vectors, and random
// stimulus compared every cycle against a run-length reference model.
module tb_seg7_scan_encoder;

  localparam int S = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [6:0]  seg_n = 7'h7F;
  logic [3:0]  an_n = 4'hF;
  logic        out_ready = 1'b0;
  logic [15:0] value;
  logic        value_valid;
  logic [3:0]  invalid_mask;
  logic        frame_err;

  seg7_scan_encoder #(.STABLE_CYCLES(S)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .seg_n        (seg_n),
    .an_n         (an_n),
    .out_ready    (out_ready),
    .value        (value),
    .value_valid  (value_valid),
    .invalid_mask (invalid_mask),
    .frame_err    (frame_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  logic [6:0] hexTab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  logic [3:0] multiTab [5] = '{4'b0011, 4'b0101, 4'b1001, 4'b0000, 4'b1100};

  typedef struct {
    logic [6:0] pat;
    logic [3:0] nib;
    logic       inv;
  } vec_t;
  vec_t vecs [18];

  // Reference model state: frame contents, pending effect of the last sample,
  // and the length of the current run of identical single-digit samples.
  logic        mPresent;
  logic [3:0]  mCaptured;
  logic [3:0]  mNib [4];
  logic [3:0]  mInv;
  logic        mErr;
  logic        pendCap;
  logic [1:0]  pendK;
  logic [6:0]  pendPat;
  logic        pendErr;
  int          runLen;
  logic [10:0] prevPair;

  // Frame monitor.
  logic        frameSeen;
  logic [15:0] frameVal;
  logic [3:0]  frameInv;
  logic        frameErr;
  logic        prevValid;
  logic        sawOne;
  int          validCycles;

  function automatic void decodeRef(input logic [6:0] pat, output logic [3:0] nib, output logic inv);
    nib = 4'h0;
    inv = 1'b1;
    for (int n = 0; n < 16; n++) begin
      if (hexTab[n] == pat) begin
        nib = 4'(n);
        inv = 1'b0;
      end
    end
  endfunction

  task automatic modelReset();
    mPresent  = 1'b0;
    mCaptured = 4'b0000;
    for (int i = 0; i < 4; i++) mNib[i] = 4'h0;
    mInv      = 4'b0000;
    mErr      = 1'b0;
    pendCap   = 1'b0;
    pendK     = 2'd0;
    pendPat   = 7'h7F;
    pendErr   = 1'b0;
    runLen    = 0;
    prevPair  = {4'hF, 7'h7F};
    prevValid = 1'b0;
  endtask

  task automatic modelEdge(input logic [3:0] an, input logic [6:0] seg, input logic rdy);
    logic [3:0] nib;
    logic       inv;
    logic       goPresent;
    int         lows;
    int         k;
    if (!mPresent) begin
      goPresent = (mCaptured == 4'hF);
      if (pendErr) mErr = 1'b1;
      if (pendCap) begin
        decodeRef(pendPat, nib, inv);
        mNib[pendK]      = nib;
        mInv[pendK]      = inv;
        mCaptured[pendK] = 1'b1;
      end
      if (goPresent) mPresent = 1'b1;
    end else if (rdy) begin
      mPresent  = 1'b0;
      mCaptured = 4'b0000;
      mErr      = 1'b0;
    end
    lows = 0;
    k = 0;
    for (int i = 0; i < 4; i++) begin
      if (!an[i]) begin
        lows++;
        k = i;
      end
    end
    pendCap = 1'b0;
    pendErr = 1'b0;
    if (lows == 1) begin
      if ({an, seg} == prevPair) runLen++;
      else runLen = 1;
      pendCap = (runLen == S);
      pendK   = 2'(k);
      pendPat = seg;
    end else begin
      runLen  = 0;
      pendErr = (lows >= 2);
    end
    prevPair = {an, seg};
  endtask

  task automatic checkOutput(input string name, input logic [15:0] eV, input logic eValid,
                             input logic [3:0] eInv, input logic eErr);
    checks++;
    if ({value, value_valid, invalid_mask, frame_err} === {eV, eValid, eInv, eErr}) begin
      passes++;
    end else begin
      $display("[TB] FAIL %s @%0t: got value=%h valid=%b inv=%b err=%b, expected value=%h valid=%b inv=%b err=%b",
               name, $time, value, value_valid, invalid_mask, frame_err, eV, eValid, eInv, eErr);
    end
  endtask

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
  endtask

  task automatic applyStimulus(input logic [3:0] an, input logic [6:0] seg, input logic rdy);
    an_n      = an;
    seg_n     = seg;
    out_ready = rdy;
    @(posedge clk);
    modelEdge(an, seg, rdy);
    #1;
    checkOutput("cycle", {mNib[3], mNib[2], mNib[1], mNib[0]}, mPresent, mInv, mErr);
    if (value_valid && !prevValid) begin
      frameSeen = 1'b1;
      frameVal  = value;
      frameInv  = invalid_mask;
      frameErr  = frame_err;
    end
    if (value_valid) validCycles++;
    if (value[3:0] == 4'h1) sawOne = 1'b1;
    prevValid = value_valid;
  endtask

  task automatic driveDigit(input int k, input logic [6:0] pat, input int hold, input logic rdy);
    logic [3:0] an;
    an = 4'b1111 ^ (4'b0001 << k);
    repeat (hold) applyStimulus(an, pat, rdy);
  endtask

  task automatic driveFrame(input logic [6:0] p3, input logic [6:0] p2, input logic [6:0] p1,
                            input logic [6:0] p0, input logic rdy);
    frameSeen   = 1'b0;
    validCycles = 0;
    driveDigit(3, p3, 8, rdy);
    driveDigit(2, p2, 8, rdy);
    driveDigit(1, p1, 8, rdy);
    driveDigit(0, p0, 8, rdy);
  endtask

  task automatic expectFrame(input string name, input logic [15:0] eV, input logic [3:0] eInv, input logic eErr);
    int budget;
    budget = 0;
    while (!frameSeen && budget < 20) begin
      applyStimulus(4'hF, 7'h7F, 1'b1);
      budget++;
    end
    if (!frameSeen) begin
      checks++;
      $display("[TB] FAIL %s: no frame within 20 cycles, got value_valid=%b, expected 1", name, value_valid);
    end else begin
      checkVal(name, {11'd0, frameVal, frameInv, frameErr}, {11'd0, eV, eInv, eErr});
    end
    frameSeen = 1'b0;
  endtask

  task automatic doReset(input string name);
    rst_n = 1'b0;
    #1;
    modelReset();
    checkOutput(name, 16'h0000, 1'b0, 4'b0000, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [15:0] ev;
    logic [3:0]  einv;
    logic [6:0]  p [4];
    logic [3:0]  an;
    logic [6:0]  seg;
    int          hold;
    int          r;

    for (int i = 0; i < 16; i++) vecs[i] = '{hexTab[i], 4'(i), 1'b0};
    vecs[16] = '{7'h7F, 4'h0, 1'b1};
    vecs[17] = '{7'h55, 4'h0, 1'b1};

    frameSeen   = 1'b0;
    sawOne      = 1'b0;
    validCycles = 0;
    modelReset();

    #2;
    doReset("reset_outputs");

    // Clean frame: 3,5,C,8.
    driveFrame(7'h30, 7'h12, 7'h46, 7'h00, 1'b1);
    expectFrame("clean_frame", 16'h35C8, 4'b0000, 1'b0);
    repeat (3) applyStimulus(4'hF, 7'h7F, 1'b1);
    checkVal("clean_valid_cycles", validCycles, 1);

    // Glitch: a 3-cycle "1" on digit 0 must never land.
    frameSeen = 1'b0;
    driveDigit(3, 7'h19, 8, 1'b1);
    driveDigit(2, 7'h02, 8, 1'b1);
    driveDigit(1, 7'h78, 8, 1'b1);
    sawOne = 1'b0;
    driveDigit(0, 7'h79, 3, 1'b1);
    driveDigit(0, 7'h24, 8, 1'b1);
    expectFrame("glitch_frame", 16'h4672, 4'b0000, 1'b0);
    checkVal("glitch_never_one", {31'd0, sawOne}, 32'd0);

    // Invalid pattern on digit 1.
    driveFrame(7'h00, 7'h10, 7'h7F, 7'h08, 1'b1);
    expectFrame("invalid_frame", 16'h890A, 4'b0010, 1'b0);

    // Multiple enables for one cycle, then a clean frame.
    frameSeen = 1'b0;
    driveDigit(3, 7'h40, 8, 1'b1);
    driveDigit(2, 7'h79, 8, 1'b1);
    applyStimulus(4'b0011, 7'h24, 1'b1);
    driveDigit(1, 7'h24, 8, 1'b1);
    driveDigit(0, 7'h30, 8, 1'b1);
    expectFrame("multi_err_frame", 16'h0123, 4'b0000, 1'b1);
    driveFrame(7'h19, 7'h12, 7'h02, 7'h78, 1'b1);
    expectFrame("after_err_frame", 16'h4567, 4'b0000, 1'b0);

    // Backpressure: frame must hold while digits keep changing.
    driveFrame(7'h00, 7'h10, 7'h08, 7'h03, 1'b0);
    checkVal("bp_frame", {11'd0, frameSeen, frameVal, frameInv, frameErr}, {11'd0, 1'b1, 16'h89AB, 4'b0000, 1'b0});
    for (int i = 0; i < 20; i++) begin
      applyStimulus(4'b1111 ^ (4'b0001 << (i / 5)), hexTab[i / 5 + 1], 1'b0);
      checkVal("bp_hold", {15'd0, value_valid, value}, {15'd0, 1'b1, 16'h89AB});
    end
    applyStimulus(4'hF, 7'h7F, 1'b1);
    checkVal("bp_release", {31'd0, value_valid}, 32'd0);
    driveFrame(7'h46, 7'h21, 7'h06, 7'h0E, 1'b1);
    expectFrame("bp_next_frame", 16'hCDEF, 4'b0000, 1'b0);

    // Reset after two captures.
    driveDigit(3, 7'h40, 8, 1'b1);
    driveDigit(2, 7'h79, 8, 1'b1);
    doReset("reset_mid_frame");
    driveFrame(7'h24, 7'h30, 7'h19, 7'h12, 1'b1);
    expectFrame("post_reset_frame", 16'h2345, 4'b0000, 1'b0);

    // Table: each vector shown on one digit, the rest show 0.
    for (int i = 0; i < 18; i++) begin
      for (int d = 0; d < 4; d++) p[d] = 7'h40;
      p[i % 4] = vecs[i].pat;
      ev   = 16'(vecs[i].nib) << (4 * (i % 4));
      einv = 4'(vecs[i].inv) << (i % 4);
      driveFrame(p[3], p[2], p[1], p[0], 1'b1);
      expectFrame("table_frame", ev, einv, 1'b0);
    end

    // Random dwells, enables and backpressure against the model.
    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(0, 9);
      if (r <= 6) an = 4'b1111 ^ (4'b0001 << $urandom_range(0, 3));
      else if (r == 7) an = 4'hF;
      else an = multiTab[$urandom_range(0, 4)];
      if ($urandom_range(0, 4) != 0) seg = hexTab[$urandom_range(0, 15)];
      else seg = 7'($urandom);
      hold = $urandom_range(1, 7);
      repeat (hold) applyStimulus(an, seg, ($urandom_range(0, 3) != 0));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/seg7_scan_encoder.md
# seg7_scan_encoder

Reverse path of the board's hex 7-segment decoder: samples a time-multiplexed, active-low 4-digit seven-segment bus and recovers the 4-bit code behind each digit. It debounces each digit's pattern, maps it back to a nibble, and assembles a 16-bit frame. The frame is presented to a consumer over a valid/ready handshake. Used as a display readback and self-check block beside the display driver.

## Interface
- `STABLE_CYCLES`, default 4: consecutive identical registered samples required to capture a digit; legal range ≥2.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `seg_n` in 7: segment bus, active-low; bit0=a … bit6=g.
- `an_n` in 4: digit enables, active-low; bit k selects digit k.
- `out_ready` in 1: consumer accepts the frame.
- `value` out 16: `value[4k+3:4k]` = nibble of digit k.
- `value_valid` out 1: frame present.
- `invalid_mask` out 4: bit k set = digit k pattern not in the hex table (its nibble reads 0).
- `frame_err` out 1: multiple enables were seen low during frame collection.

## Operation
- **Input stage.** `seg_n` and `an_n` are registered once (sample stage); all logic works on the registered copies.
- **Hex table.** Active-low patterns for nibbles 0..F:
  - 0..7: 0x40, 0x79, 0x24, 0x30, 0x19, 0x12, 0x02, 0x78
  - 8..F: 0x00, 0x10, 0x08, 0x03, 0x46, 0x21, 0x06, 0x0E
  - Any other pattern is invalid: nibble 0, invalid flag 1.
- **Digit select.** Exactly one `an_n` bit low means digit k is active.
  - All high: idle; the stability counter clears.
  - Two or more low: the counter clears and the sticky error flag sets (collection state only).
- **Stability counter.** The sample pair (k, pattern) is compared with the previous sample pair.
  - Different: the counter loads 1.
  - Identical: the counter increments, saturating at `STABLE_CYCLES`.
  - Width: $clog2(STABLE_CYCLES+1).
- **Capture.** When the counter becomes equal to `STABLE_CYCLES`, digit k is captured: nibble, invalid bit, and captured[k] set.
  - Exactly one capture per dwell; saturation prevents re-capture.
  - A digit may be re-captured in the same frame after its pattern or enable changes; the last capture wins.
- **FSM states.**
  - COLLECT: captures are enabled. When captured == 4'b1111 → PRESENT.
  - PRESENT: `value_valid`=1. `value`, `invalid_mask` and `frame_err` are frozen. Captures are ignored, but the input stage and counter keep running.
  - On `value_valid && out_ready` → COLLECT. This clears captured[3:0], the sticky error and `value_valid`.
- **Mid-operation reset.** Asynchronous reset at any time discards the partial frame.

## Timing
- **Reset values.**
  - Outputs: `value`=0, `value_valid`=0, `invalid_mask`=0, `frame_err`=0.
  - Internal: state COLLECT, counter 0, captured 0, sample registers seg=0x7F, an=0xF.
- **Capture latency.** For an input held from edge t, the capture registers update at edge t+`STABLE_CYCLES`. This is 1 sample stage plus `STABLE_CYCLES`−1 increments.
- **Frame valid.** `value_valid` rises on the edge after the fourth capture.
- **Handshake.** The transfer happens on an edge where `value_valid`=1 and `out_ready`=1. `value_valid` is 0 the following cycle.
  - `out_ready` may be held high; the minimum gap between frames is set by capture latency.
  - `value_valid` never drops without a handshake.
- **Simultaneous events.**
  - Handshake plus a capture in the same cycle: the capture is dropped (state was PRESENT).
  - Counter reaching `STABLE_CYCLES` on the COLLECT→PRESENT edge: this cannot occur, because the transition follows the fourth capture.

## Structure
- Package `seg7_pkg` holds:
  - the 16 active-low pattern constants (SEG7_HEX_0..F)
  - the FSM state enum (COLLECT, PRESENT)
  - the blank pattern constant 0x7F
- Sub-module `seg7_pattern_to_nibble`: combinational lookup, 7-bit pattern → {invalid, nibble[3:0]}. It is shared with scoreboards.
- Top level holds the sample registers, the stability counter, the capture registers and the FSM.

## Test plan
- **Clean frame.** `STABLE_CYCLES`=4, `out_ready`=1. Drive each pair for 8 cycles: (an_n=0111, seg 0x30), (1011, 0x12), (1101, 0x46), (1110, 0x00). Required: `value`=0x35C8, `invalid_mask`=0, `frame_err`=0, `value_valid` high one cycle.
- **Glitch rejection.** Digit 0 shows 0x79 for 3 cycles, then 0x24 for 8 cycles. Required: digit 0 captures 2, and 1 is never captured.
- **Invalid pattern.** Digit 1 shows 0x7F; the other digits are valid. Required: `invalid_mask`=4'b0010 and `value[7:4]`=0.
- **Multiple enables.** an_n=0011 for one cycle mid-frame. Required: `frame_err`=1 for that frame and 0 for the next clean frame.
- **Backpressure.** `out_ready`=0 for 20 cycles while digits change. Required: `value` and `value_valid` stay stable. After `out_ready` rises, `value_valid`=0 the next cycle and the next frame contains only post-handshake captures.
- **Reset mid-frame.** Assert `rst_n` low after 2 captures. Required: all outputs 0 immediately. The following full frame reflects only new stimulus.
